box_motion: RTL and testbench
=============================

BOX_MOTION -- requirements
Module: box_motion

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all registers are rising-edge.
REQ-002 SHALL have port hard_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port game_en, input, 1 bit: game FSM playing enable (level).
REQ-004 SHALL have port game_reset, input, 1 bit: single-cycle pulse from the game FSM that restarts gameplay.
REQ-005 SHALL have port up, input, 1 bit: debounced level of the player's jump button.
REQ-006 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame (60 Hz).
REQ-007 SHALL have port pipe_x, input, 10 bits: left x of the nearest pipe.
REQ-008 SHALL have ports gap_top and gap_bot, input, 10 bits each: inclusive y bounds of that pipe's opening.
REQ-009 SHALL have port box_y, output, 10 bits: top y of the box in pixels.
REQ-010 SHALL have port collision, output, 1 bit: level that tells the game FSM the box has hit something.
REQ-011 SHALL have port box_state, output, 2 bits: current motion state.

Function
REQ-012 SHALL implement the states HOLD=2'b00, FLY=2'b01 and DEAD=2'b10; 2'b11 is illegal and SHALL recover to HOLD on the next cycle.
REQ-013 HOLD: box_y=Y_START (232), velocity 0, collision 0; SHALL move to FLY in the cycle after game_en is sampled high.
REQ-014 FLY: box_y and velocity SHALL update only on cycles with frame_tick=1; they SHALL hold on all other cycles.
REQ-015 A rising edge of up (up=1 while the up register holds 0) SHALL set a jump-pending flag; the flag SHALL clear on the next frame_tick; several edges within one frame count as one jump.
REQ-016 On frame_tick with jump pending, or with an edge in that same cycle, velocity SHALL become JUMP_VEL (-8); otherwise velocity SHALL become min(velocity+GRAVITY(1), VEL_MAX(+10)).
REQ-017 Velocity SHALL be 6-bit two's complement; the new y SHALL be computed as signed 12-bit (y + new velocity) and clamped to the range [0, FLOOR_Y-BOX_SIZE] = [0, 464].
REQ-018 Timing: frame_tick high in cycle T SHALL give the new box_y in T+1; collision SHALL be evaluated from the registered box_y and registered, becoming visible in T+2.
REQ-019 Collision SHALL occur when box_y equals 464 (floor), or when the x ranges [BOX_X, BOX_X+15] and [pipe_x, pipe_x+PIPE_W-1] overlap AND (box_y < gap_top OR box_y+15 > gap_bot); BOX_X=100, PIPE_W=52.
REQ-020 On collision, or if game_en falls while in FLY, the state SHALL become DEAD; collision SHALL stay at 1 in DEAD.
REQ-021 DEAD: box_y and velocity SHALL be frozen; up and frame_tick SHALL be ignored.
REQ-022 game_reset SHALL force HOLD, Y_START, velocity 0, collision 0 and a cleared jump flag from any state; it SHALL take priority over frame_tick, up and game_en in the same cycle.
REQ-023 If the x ranges do not overlap, pipe inputs SHALL have no effect; pipe inputs SHALL be sampled combinationally each cycle.

Reset
REQ-024 hard_reset_n=0 at a rising edge SHALL set the state to HOLD, box_y=232, velocity 0, collision 0, jump flag 0 and the up edge register 0.
REQ-025 hard_reset_n SHALL take priority over game_reset and override any operation in progress (mid-flight, mid-frame).

Configuration
REQ-026 When macro CEIL_COLLISION_EN is defined, a clamped box_y of 0 SHALL also count as a collision.
REQ-027 When CEIL_COLLISION_EN is undefined, box_y SHALL clamp at 0 with no collision and velocity SHALL be unchanged.

Structure
REQ-028 Package flappy_pkg SHALL hold the state encoding plus SCREEN_H=480, FLOOR_Y, BOX_X, BOX_SIZE, PIPE_W, Y_START, GRAVITY, JUMP_VEL and VEL_MAX.
REQ-029 Sub-module box_collide (combinational: box_y, pipe_x, gap_top, gap_bot -> hit) SHALL contain the overlap test; the registers and FSM SHALL stay in box_motion.

Verification
REQ-030 Reset, then game_en=1 and one frame_tick with no up -> state FLY, box_y=233, velocity=+1.
REQ-031 In FLY at y=232, pulse up then frame_tick -> box_y=224; the next tick with no up -> box_y=217 (velocity -7).
REQ-032 No up for 40 frames from Y_START -> velocity saturates at +10, box_y clamps to 464, collision=1 two cycles after that tick, state DEAD; later frame_ticks leave box_y=464.
REQ-033 pipe_x=90, gap_top=200, gap_bot=300, box_y=232 -> collision=0; change gap_top to 240 -> collision=1 one cycle later; pipe_x=200 with gap_top=240 -> collision=0.
REQ-034 In DEAD, assert game_reset together with frame_tick and up -> next cycle state HOLD, box_y=232, collision=0.
REQ-035 Drive y to 0 with repeated jumps -> collision=1 when CEIL_COLLISION_EN is defined, collision=0 with box_y=0 when it is undefined.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants, motion-state encoding and the y-clamp helper for the
// flappy box datapath.
package flappy_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        FLY  = 2'b01,
        DEAD = 2'b10
    } box_state_e;

    localparam int SCREEN_H = 480;
    localparam int FLOOR_Y  = SCREEN_H;
    localparam int BOX_X    = 100;
    localparam int BOX_SIZE = 16;
    localparam int PIPE_W   = 52;
    localparam int Y_START  = 232;
    localparam int GRAVITY  = 1;
    localparam int JUMP_VEL = -8;
    localparam int VEL_MAX  = 10;
    localparam int Y_MAX    = FLOOR_Y - BOX_SIZE;

    // Saturate a signed candidate position into [0, Y_MAX].
    function automatic logic [9:0] clamp_y(input logic signed [11:0] y_s);
        logic [9:0] r;
        if (y_s < 0)
            r = '0;
        else if (y_s > Y_MAX)
            r = Y_MAX[9:0];
        else
            r = y_s[9:0];
        return r;
    endfunction

endpackage

// File: rtl/box_motion_if.sv
// Game-side signal bundle for box_motion: control/pipe inputs and box outputs.
interface box_motion_if;
    logic       game_en;
    logic       game_reset;
    logic       up;
    logic       frame_tick;
    logic [9:0] pipe_x;
    logic [9:0] gap_top;
    logic [9:0] gap_bot;
    logic [9:0] box_y;
    logic       collision;
    logic [1:0] box_state;

    modport master (
        output game_en, game_reset, up, frame_tick, pipe_x, gap_top, gap_bot,
        input  box_y, collision, box_state
    );

    modport slave (
        input  game_en, game_reset, up, frame_tick, pipe_x, gap_top, gap_bot,
        output box_y, collision, box_state
    );
endinterface

// File: rtl/box_collide.sv
// Combinational hit test of the box against the floor and the nearest pipe.
// Define CEIL_COLLISION_EN to make y == 0 a hit as well.
module box_collide
    import flappy_pkg::*;
(
    input  logic [9:0] box_y,
    input  logic [9:0] pipe_x,
    input  logic [9:0] gap_top,
    input  logic [9:0] gap_bot,
    output logic       hit
);
    localparam logic [10:0] BOX_L  = BOX_X[10:0];
    localparam logic [10:0] BOX_R  = 11'(BOX_X + BOX_SIZE - 1);
    localparam logic [10:0] PIPE_E = 11'(PIPE_W - 1);
    localparam logic [10:0] BOX_E  = 11'(BOX_SIZE - 1);

    logic [10:0] pipe_r;
    logic [10:0] box_b;
    logic        overlap;
    logic        outside_gap;
    logic        floor_hit;
    logic        ceil_hit;

    // 11-bit sums so pipe_x near 1023 cannot wrap into the box column.
    assign pipe_r      = {1'b0, pipe_x} + PIPE_E;
    assign box_b       = {1'b0, box_y} + BOX_E;
    assign overlap     = ({1'b0, pipe_x} <= BOX_R) && (pipe_r >= BOX_L);
    assign outside_gap = (box_y < gap_top) || (box_b > {1'b0, gap_bot});
    assign floor_hit   = (box_y == Y_MAX[9:0]);

`ifdef CEIL_COLLISION_EN
    assign ceil_hit = (box_y == 10'd0);
`else
    assign ceil_hit = 1'b0;
`endif

    assign hit = floor_hit | ceil_hit | (overlap & outside_gap);

endmodule

// File: rtl/box_motion.sv
// Box vertical motion FSM (HOLD/FLY/DEAD) with frame-rate physics and a
// registered collision flag. Ceiling collision is enabled by CEIL_COLLISION_EN.
module box_motion
    import flappy_pkg::*;
(
    input  logic         clk,
    input  logic         hard_reset_n,
    box_motion_if.slave  bm
);
    localparam logic signed [5:0] JUMP_S  = JUMP_VEL[5:0];
    localparam logic signed [5:0] GRAV_S  = GRAVITY[5:0];
    localparam logic signed [5:0] VMAX_S  = VEL_MAX[5:0];
    localparam logic [9:0]        YSTRT_V = Y_START[9:0];

    box_state_e        state_q;
    logic [9:0]        y_q;
    logic signed [5:0] vel_q;
    logic              collision_q;
    logic              jump_q;
    logic              up_q;

    logic              hit;
    logic              up_edge;
    logic signed [5:0] vel_d;
    logic signed [11:0] y_sum;
    logic [9:0]        y_d;

    box_collide u_collide (
        .box_y   (y_q),
        .pipe_x  (bm.pipe_x),
        .gap_top (bm.gap_top),
        .gap_bot (bm.gap_bot),
        .hit     (hit)
    );

    assign up_edge = bm.up & ~up_q;

    // Candidate velocity/position applied only on a frame tick in FLY.
    always_comb begin
        vel_d = vel_q;
        if (jump_q || up_edge)
            vel_d = JUMP_S;
        else if (vel_q >= VMAX_S)
            vel_d = VMAX_S;
        else
            vel_d = vel_q + GRAV_S;
        y_sum = $signed({2'b00, y_q}) + $signed({{6{vel_d[5]}}, vel_d});
        y_d   = clamp_y(y_sum);
    end

    always_ff @(posedge clk) begin
        if (!hard_reset_n) begin
            state_q     <= HOLD;
            y_q         <= YSTRT_V;
            vel_q       <= '0;
            collision_q <= 1'b0;
            jump_q      <= 1'b0;
            up_q        <= 1'b0;
        end else begin
            up_q <= bm.up;
            if (bm.game_reset) begin
                state_q     <= HOLD;
                y_q         <= YSTRT_V;
                vel_q       <= '0;
                collision_q <= 1'b0;
                jump_q      <= 1'b0;
            end else begin
                case (state_q)
                    HOLD: begin
                        y_q         <= YSTRT_V;
                        vel_q       <= '0;
                        collision_q <= 1'b0;
                        jump_q      <= 1'b0;
                        if (bm.game_en)
                            state_q <= FLY;
                    end
                    FLY: begin
                        collision_q <= hit;
                        // A hit or a dropped enable freezes the box where it is.
                        if (hit || !bm.game_en) begin
                            state_q <= DEAD;
                        end else if (bm.frame_tick) begin
                            vel_q  <= vel_d;
                            y_q    <= y_d;
                            jump_q <= 1'b0;
                        end else if (up_edge) begin
                            jump_q <= 1'b1;
                        end
                    end
                    DEAD: begin
                    end
                    default: state_q <= HOLD;
                endcase
            end
        end
    end

    assign bm.box_y     = y_q;
    assign bm.collision = collision_q;
    assign bm.box_state = state_q;

endmodule

// File: tb/tb_box_motion.sv
// Self-checking bench for box_motion: directed sequences, a collision vector
// table and a randomized run against a frame-level reference model.
module tb_box_motion;

    logic clk = 1'b0;
    logic hard_reset_n;
    box_motion_if bm();

    box_motion dut (
        .clk          (clk),
        .hard_reset_n (hard_reset_n),
        .bm           (bm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: state 0=HOLD 1=FLY 2=DEAD, y/vel as plain integers.
    int m_st, m_y, m_vel, m_coll;
    bit m_jump, m_up;

    typedef struct {
        int px;
        int gt;
        int gb;
        int exp_coll;
    } cvec_t;

    function automatic bit ref_hit(int y, int px, int gt, int gb);
        bit ov = 0;
        for (int x = 100; x < 116; x++)
            if (x >= px && x <= px + 51) ov = 1;
        if (y == 464) return 1;
`ifdef CEIL_COLLISION_EN
        if (y == 0) return 1;
`endif
        return ov && (y < gt || y + 15 > gb);
    endfunction

    task automatic model_step();
        bit edge_ = bm.up && !m_up;
        bit h;
        if (!hard_reset_n) begin
            m_st = 0; m_y = 232; m_vel = 0; m_coll = 0; m_jump = 0; m_up = 0;
            return;
        end
        if (bm.game_reset) begin
            m_st = 0; m_y = 232; m_vel = 0; m_coll = 0; m_jump = 0;
        end else if (m_st == 0) begin
            m_coll = 0; m_jump = 0;
            if (bm.game_en) m_st = 1;
        end else if (m_st == 1) begin
            h = ref_hit(m_y, int'(bm.pipe_x), int'(bm.gap_top), int'(bm.gap_bot));
            m_coll = h;
            if (h || !bm.game_en) begin
                m_st = 2;
            end else if (bm.frame_tick) begin
                if (m_jump || edge_) m_vel = -8;
                else m_vel = (m_vel + 1 > 10) ? 10 : m_vel + 1;
                m_y = m_y + m_vel;
                if (m_y < 0) m_y = 0;
                if (m_y > 464) m_y = 464;
                m_jump = 0;
            end else if (edge_) begin
                m_jump = 1;
            end
        end
        m_up = bm.up;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, " box_y"}, int'(bm.box_y), m_y);
        chk({tag, " state"}, int'(bm.box_state), m_st);
        chk({tag, " collision"}, int'(bm.collision), m_coll);
    endtask

    task automatic defaults();
        bm.game_en = 0; bm.game_reset = 0; bm.up = 0; bm.frame_tick = 0;
        bm.pipe_x = 10'd600; bm.gap_top = 10'd0; bm.gap_bot = 10'd1023;
    endtask

    task automatic start_fly();
        bm.game_reset = 1; cyc(); bm.game_reset = 0;
        bm.game_en = 1; cyc();
    endtask

    task automatic tick_frame();
        bm.frame_tick = 1; cyc(); bm.frame_tick = 0;
    endtask

    task automatic jump_frame();
        bm.up = 1; cyc(); bm.up = 0; tick_frame();
    endtask

    cvec_t cv[10];

    initial begin
        int n;
        cv[0] = '{90, 200, 300, 0};
        cv[1] = '{90, 240, 300, 1};
        cv[2] = '{200, 240, 300, 0};
        cv[3] = '{116, 240, 300, 0};
        cv[4] = '{115, 240, 300, 1};
        cv[5] = '{48, 240, 300, 0};
        cv[6] = '{49, 240, 300, 1};
        cv[7] = '{90, 232, 247, 0};
        cv[8] = '{90, 233, 300, 1};
        cv[9] = '{90, 200, 246, 1};

        defaults();
        hard_reset_n = 0;
        cyc(); cyc();
        hard_reset_n = 1;
        chk("reset box_y", int'(bm.box_y), 232);
        chk("reset state", int'(bm.box_state), 0);
        chk("reset collision", int'(bm.collision), 0);
        $display("reset: y=%0d state=%0d", bm.box_y, bm.box_state);

        // First frame from HOLD: velocity 0 -> +1.
        bm.game_en = 1; cyc();
        chk("enter fly", int'(bm.box_state), 1);
        tick_frame();
        chk("first tick y", int'(bm.box_y), 233);
        chk("first tick state", int'(bm.box_state), 1);
        tick_frame();
        chk("second tick y", int'(bm.box_y), 235);
        $display("first frames: y=%0d", bm.box_y);

        // Jump from rest, then gravity recovery.
        start_fly();
        jump_frame();
        chk("jump y", int'(bm.box_y), 224);
        tick_frame();
        chk("post jump y", int'(bm.box_y), 217);
        bm.up = 1; cyc(); bm.up = 0; cyc(); bm.up = 1; cyc(); bm.up = 0;
        tick_frame();
        chk("double edge one jump", int'(bm.box_y), 209);
        tick_frame();
        chk("after double edge", int'(bm.box_y), 202);
        bm.up = 1; bm.frame_tick = 1; cyc(); bm.frame_tick = 0;
        chk("same-cycle edge jump", int'(bm.box_y), 194);
        tick_frame();
        chk("held up no rejump", int'(bm.box_y), 187);
        bm.up = 0; cyc();
        chk_model("jump seq");
        $display("jump sequence: y=%0d", bm.box_y);

        // Free fall to the floor.
        start_fly();
        n = 0;
        while (n < 60) begin
            tick_frame();
            n++;
            if (bm.box_y == 10'd464) break;
            cyc();
        end
        chk("floor tick count", n, 28);
        chk("floor y", int'(bm.box_y), 464);
        chk("floor collision T+1", int'(bm.collision), 0);
        cyc();
        chk("floor collision T+2", int'(bm.collision), 1);
        chk("floor dead", int'(bm.box_state), 2);
        for (int i = 0; i < 3; i++) begin
            jump_frame();
        end
        chk("dead frozen y", int'(bm.box_y), 464);
        chk_model("floor seq");
        $display("floor: ticks=%0d y=%0d coll=%0d", n, bm.box_y, bm.collision);

        // game_reset wins over frame_tick and up.
        bm.game_reset = 1; bm.frame_tick = 1; bm.up = 1; cyc();
        bm.game_reset = 0; bm.frame_tick = 0; bm.up = 0;
        chk("game_reset state", int'(bm.box_state), 0);
        chk("game_reset y", int'(bm.box_y), 232);
        chk("game_reset collision", int'(bm.collision), 0);
        $display("game_reset from DEAD: state=%0d", bm.box_state);

        // Pipe collision vectors at y=232.
        for (int i = 0; i < 10; i++) begin
            bm.pipe_x  = 10'(cv[i].px);
            bm.gap_top = 10'(cv[i].gt);
            bm.gap_bot = 10'(cv[i].gb);
            start_fly();
            chk($sformatf("pipe%0d pre", i), int'(bm.collision), 0);
            cyc();
            chk($sformatf("pipe%0d collision", i), int'(bm.collision), cv[i].exp_coll);
            chk($sformatf("pipe%0d state", i), int'(bm.box_state), cv[i].exp_coll ? 2 : 1);
            $display("pipe vec %0d: px=%0d gap=[%0d,%0d] coll=%0d", i,
                     cv[i].px, cv[i].gt, cv[i].gb, bm.collision);
        end
        defaults();

        // Climb to the ceiling.
        start_fly();
        n = 0;
        while (n < 60 && bm.box_y != 10'd0) begin
            jump_frame();
            n++;
        end
        chk("ceiling jumps", n, 29);
        cyc();
        chk("ceiling y", int'(bm.box_y), 0);
`ifdef CEIL_COLLISION_EN
        chk("ceiling collision", int'(bm.collision), 1);
        chk("ceiling state", int'(bm.box_state), 2);
`else
        chk("ceiling collision", int'(bm.collision), 0);
        chk("ceiling state", int'(bm.box_state), 1);
`endif
        $display("ceiling: jumps=%0d y=%0d coll=%0d", n, bm.box_y, bm.collision);

        // game_en drop in FLY, then hard reset overriding game_reset mid-flight.
        start_fly();
        tick_frame();
        bm.game_en = 0; cyc();
        chk("enable drop dead", int'(bm.box_state), 2);
        start_fly();
        tick_frame();
        hard_reset_n = 0; bm.game_reset = 1; bm.frame_tick = 1; cyc();
        hard_reset_n = 1; bm.game_reset = 0; bm.frame_tick = 0;
        chk("hard reset y", int'(bm.box_y), 232);
        chk("hard reset state", int'(bm.box_state), 0);
        $display("enable drop / hard reset: state=%0d", bm.box_state);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            hard_reset_n  = ($urandom_range(0, 599) != 0);
            bm.game_reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 199) == 0) bm.game_en = 0;
            else if ($urandom_range(0, 9) == 0) bm.game_en = 1;
            bm.frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) bm.up = ~bm.up;
            if ($urandom_range(0, 29) == 0) begin
                bm.pipe_x  = 10'($urandom_range(0, 300));
                bm.gap_top = 10'($urandom_range(0, 400));
                bm.gap_bot = 10'(int'(bm.gap_top) + $urandom_range(20, 200));
            end
            cyc();
            chk_model($sformatf("rand%0d", c));
        end
        $display("random run: 3000 cycles");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
